// File: rtl/numberle_pkg.sv
// Shared definitions for the Numberle target picker: digit type, FSM encoding
// and the largest legal BCD digit.
package numberle_pkg;

    localparam int NUM_DIGITS_DEF = 4;

    localparam logic [3:0] MAX_DIGIT = 4'd9;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

endpackage

// File: rtl/numberle_draw_strobe.sv
// Modulo-DECIM counter that marks the cycle in which a decimated LFSR nibble
// is evaluated; held at zero while i_Clr is high.
module numberle_draw_strobe
    import numberle_pkg::*;
#(
    parameter int DECIM = 4
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Clr,
    output logic o_Strobe
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: clear, wrap at DECIM-1, or advance
    always_comb begin
        cnt_d = cnt_q;
        if (i_Clr) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // counter register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Strobe = ~i_Clr & (cnt_q == CNT_LAST);

endmodule

// File: rtl/numberle_target_picker.sv
// Draws NUM_DIGITS uniform BCD digits from decimated LFSR nibbles by rejection
// sampling. Optional macro NUMBERLE_UNIQUE_DIGITS_EN forbids repeated digits.
module numberle_target_picker
    import numberle_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int DECIM      = 4,
    parameter int MAX_DRAWS  = 64
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [15:0]             i_LFSR_Data,
    input  logic                    i_Req,
    output logic                    o_Busy,
    output logic                    o_Valid,
    output logic                    o_Err,
    output logic [4*NUM_DIGITS-1:0] o_Digits
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    localparam int DRW_W = $clog2(MAX_DRAWS + 1);

`ifdef NUMBERLE_UNIQUE_DIGITS_EN
    if (NUM_DIGITS > 10) begin : g_bad_num_digits
        $error("NUM_DIGITS must be <= 10 when digits are unique");
    end
`endif

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DRW_W-1:0]   draws_q, draws_d;
    logic [DW-1:0]      work_q, work_d;
    logic [DW-1:0]      digits_q, digits_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               strobe_s;
    logic               accept_s;
    logic               last_draw_s;
    bcd_t               nib_s;
    logic               unused_lfsr_s;

    assign nib_s         = i_LFSR_Data[3:0];
    assign unused_lfsr_s = ^i_LFSR_Data[15:4];
    assign last_draw_s   = (draws_q == DRW_W'(MAX_DRAWS - 1));

    numberle_draw_strobe #(
        .DECIM (DECIM)
    ) u_strobe (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Clr    (state_q != ST_DRAW),
        .o_Strobe (strobe_s)
    );

`ifdef NUMBERLE_UNIQUE_DIGITS_EN
    logic [9:0] used_q, used_d;

    // a nibble is a valid digit only if it is BCD and not yet drawn
    always_comb begin
        if (nib_s <= MAX_DIGIT) begin
            accept_s = ~used_q[nib_s];
        end else begin
            accept_s = 1'b0;
        end
    end

    // used-digit mask: cleared on request, marked on each accept
    always_comb begin
        used_d = used_q;
        if ((state_q == ST_IDLE) && i_Req) begin
            used_d = '0;
        end else if ((state_q == ST_DRAW) && strobe_s && accept_s) begin
            used_d[nib_s] = 1'b1;
        end else begin
            used_d = used_q;
        end
    end

    // used-digit mask register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            used_q <= '0;
        end else begin
            used_q <= used_d;
        end
    end
`else
    assign accept_s = (nib_s <= MAX_DIGIT);
`endif

    // FSM next state, working register and registered-output next values
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        draws_d  = draws_q;
        work_d   = work_q;
        digits_d = digits_q;
        busy_d   = (state_q != ST_IDLE);
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Req) begin
                    state_d = ST_DRAW;
                    idx_d   = '0;
                    draws_d = '0;
                    work_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAW: begin
                if (strobe_s) begin
                    draws_d = draws_q + DRW_W'(1);
                    if (accept_s) begin
                        // shift in so the first drawn digit ends in the MS nibble
                        work_d = DW'({work_q, nib_s});
                        idx_d  = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                            state_d = ST_DONE;
                        end else if (last_draw_s) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_DRAW;
                        end
                    end else if (last_draw_s) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_DRAW;
                    end
                end else begin
                    state_d = ST_DRAW;
                end
            end
            ST_DONE: begin
                digits_d = work_q;
                valid_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_FAIL: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, counters and output registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            draws_q  <= '0;
            work_q   <= '0;
            digits_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            draws_q  <= draws_d;
            work_q   <= work_d;
            digits_q <= digits_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign o_Busy   = busy_q;
    assign o_Valid  = valid_q;
    assign o_Err    = err_q;
    assign o_Digits = digits_q;

endmodule

// File: tb/tb_numberle_target_picker.sv
// Self-checking bench for numberle_target_picker (NUM_DIGITS=4, DECIM=4,
// MAX_DRAWS=8); LFSR nibbles are driven directly at the evaluation edges.
module tb_numberle_target_picker;

    logic        clk;
    logic        rst;
    logic [15:0] lfsr;
    logic        req;
    logic        busy;
    logic        valid;
    logic        err;
    logic [15:0] digits;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    logic [15:0] last_good;

    typedef struct {
        bit          is_err;
        logic [15:0] digits;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    numberle_target_picker #(
        .NUM_DIGITS (4),
        .DECIM      (4),
        .MAX_DRAWS  (8)
    ) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_LFSR_Data (lfsr),
        .i_Req       (req),
        .o_Busy      (busy),
        .o_Valid     (valid),
        .o_Err       (err),
        .o_Digits    (digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Request a draw, feed n nibbles (first in MS position of nibs) at the
    // evaluation edges with random filler between, then check the result.
    task automatic feed(input string name, input int n, input logic [63:0] nibs,
                        input bit exp_err, input logic [15:0] exp_dig, input bit repulse);
        int   e0;
        int   bad;
        int   t;
        exp_t ex;
        @(negedge clk);
        req  = 1'b1;
        lfsr = 16'($urandom);
        @(negedge clk);
        e0  = cyc;
        req = 1'b0;
        ex.is_err = exp_err;
        ex.digits = exp_dig;
        ex.cyc    = e0 + 4 * n + 1;
        sb.push_back(ex);
        bad = 0;
        for (int c = 1; c <= 4 * n; c++) begin
            if (c % 4 == 0) lfsr = {12'($urandom), nibs[(n - c / 4) * 4 +: 4]};
            else            lfsr = {12'($urandom), 4'($urandom_range(0, 9))};
            if (repulse) req = (c == 5);
            @(negedge clk);
            if (valid || err || (digits !== last_good)) bad++;
            if (c == 6) begin
                n_total++;
                if (busy !== 1'b1) $display("FAIL %s busy_mid: got %0b want 1", name, busy);
                else n_pass++;
            end
        end
        n_total++;
        if (bad != 0) $display("FAIL %s no_partial: %0d bad cycles want 0", name, bad);
        else n_pass++;
        t = 0;
        while (!(valid || err) && t < 40) begin
            @(negedge clk);
            t++;
        end
        ex = sb.pop_front();
        n_total++;
        if (!(valid || err)) begin
            $display("FAIL %s timeout: no valid/err within 40 cycles", name);
            return;
        end else n_pass++;
        n_total++;
        if ({err, valid} !== {ex.is_err, ~ex.is_err})
            $display("FAIL %s kind: err/valid=%0b%0b want %0b%0b", name, err, valid, ex.is_err, ~ex.is_err);
        else n_pass++;
        n_total++;
        if (digits !== (ex.is_err ? last_good : ex.digits))
            $display("FAIL %s digits: got %h want %h", name, digits, ex.is_err ? last_good : ex.digits);
        else n_pass++;
        n_total++;
        if (cyc !== ex.cyc) $display("FAIL %s latency: edge %0d want %0d", name, cyc - e0, ex.cyc - e0);
        else n_pass++;
        if (!ex.is_err) last_good = ex.digits;
        @(negedge clk);
        n_total++;
        if ({busy, valid, err} !== 3'b000)
            $display("FAIL %s after_pulse: busy/valid/err=%b want 000", name, {busy, valid, err});
        else n_pass++;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 1'b0;
        lfsr = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, valid, err, digits} !== 19'd0)
            $display("FAIL reset: busy/valid/err/digits=%b/%b/%b/%h want 0", busy, valid, err, digits);
        else n_pass++;
        last_good = 16'h0000;
    endtask

    task automatic test_no_reject();
        feed("no_reject", 4, 64'h3719, 1'b0, 16'h3719, 1'b0);
    endtask

    task automatic test_reject();
        feed("reject", 7, 64'hAF5C028, 1'b0, 16'h5028, 1'b0);
    endtask

    task automatic test_unique();
`ifdef NUMBERLE_UNIQUE_DIGITS_EN
        feed("unique", 5, 64'h44286, 1'b0, 16'h4286, 1'b0);
`else
        feed("unique", 4, 64'h4428, 1'b0, 16'h4428, 1'b0);
`endif
    endtask

    task automatic test_max_draws();
        feed("set_3719", 4, 64'h3719, 1'b0, 16'h3719, 1'b0);
        feed("max_draws", 8, 64'hCCCCCCCC, 1'b1, 16'h3719, 1'b0);
    endtask

    task automatic test_repulse();
        feed("repulse", 4, 64'h3719, 1'b0, 16'h3719, 1'b1);
    endtask

    task automatic test_abort();
        @(negedge clk);
        req  = 1'b1;
        lfsr = 16'($urandom);
        @(negedge clk);
        req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 4)      lfsr = 16'h0003;
            else if (c == 8) lfsr = 16'h0007;
            else             lfsr = {12'($urandom), 4'($urandom_range(0, 9))};
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({busy, valid, err, digits} !== 19'd0)
            $display("FAIL abort: busy/valid/err/digits=%b/%b/%b/%h want 0", busy, valid, err, digits);
        else n_pass++;
        last_good = 16'h0000;
        feed("after_abort", 4, 64'h8056, 1'b0, 16'h8056, 1'b0);
    endtask

    initial begin
        test_reset();
        test_no_reject();
        test_reject();
        test_unique();
        test_max_draws();
        test_repulse();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
